// File: rtl/jt900h_pkg.sv
// Shared definitions for the JT900H register file: transfer sizes, bank
// pointer opcodes, dump sequencer states, address-field positions and the
// byte-lane merge/extract helpers used by both the write and read paths.
package jt900h_pkg;

  // Transfer size encodings (3 is handled as long)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;

  // Bank pointer operations
  localparam logic [1:0] RFP_HOLD = 2'd0;
  localparam logic [1:0] RFP_LOAD = 2'd1;
  localparam logic [1:0] RFP_INC  = 2'd2;
  localparam logic [1:0] RFP_DEC  = 2'd3;

  // Address field positions: [1:0] byte lane, [3:2] register, [BW+3:4] bank
  localparam int ADDR_LANE_LSB = 0;
  localparam int ADDR_REG_LSB  = 2;
  localparam int ADDR_BANK_LSB = 4;
  localparam int REG_BYTES     = 4;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_t;

  // Replace only the lanes covered by size/lane; new data is right-aligned
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = old_v;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    r[7:0]   = new_v[7:0];
          2'd1:    r[15:8]  = new_v[7:0];
          2'd2:    r[23:16] = new_v[7:0];
          default: r[31:24] = new_v[7:0];
        endcase
      end
      SZ_WORD: begin
        if (lane[1]) r[31:16] = new_v[15:0];
        else         r[15:0]  = new_v[15:0];
      end
      default: r = new_v;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half/long and zero-extend it
  function automatic logic [31:0] extract_bytes(input logic [31:0] v,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
    logic [31:0] r;
    r = 32'd0;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    r = {24'd0, v[7:0]};
          2'd1:    r = {24'd0, v[15:8]};
          2'd2:    r = {24'd0, v[23:16]};
          default: r = {24'd0, v[31:24]};
        endcase
      end
      SZ_WORD: begin
        if (lane[1]) r = {16'd0, v[31:16]};
        else         r = {16'd0, v[15:0]};
      end
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jt900h_rfile_dump.sv
// Dump sequencer: walks a byte index over the whole register file with a
// valid/ready handshake. The byte itself is supplied live by the parent, so
// writes to bytes not yet sent show up in the stream.
module jt900h_rfile_dump
  import jt900h_pkg::*;
#(
  parameter int NBYTES = 81,
  localparam int IW = $clog2(NBYTES)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          dump_start,
  input  logic          dump_ready,
  input  logic [7:0]    byte_in,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic          dump_last,
  output logic [7:0]    dump_data,
  output logic [IW-1:0] idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  dump_state_t   state, state_nx;
  logic [IW-1:0] idx_nx;

  // State and index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DUMP_IDLE;
      idx   <= {IW{1'b0}};
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state: start from IDLE, step on accepted bytes, one-cycle DONE
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      DUMP_IDLE: begin
        if (cen && dump_start) begin
          state_nx = DUMP_SEND;
          idx_nx   = {IW{1'b0}};
        end else begin
          state_nx = DUMP_IDLE;
        end
      end
      DUMP_SEND: begin
        if (cen && dump_ready) begin
          if (idx == LAST_IDX) state_nx = DUMP_DONE;
          else                 idx_nx   = idx + IW'(1);
        end else begin
          state_nx = DUMP_SEND;
        end
      end
      DUMP_DONE: begin
        if (cen) state_nx = DUMP_IDLE;
        else     state_nx = DUMP_DONE;
      end
      default: begin
        state_nx = DUMP_IDLE;
        idx_nx   = {IW{1'b0}};
      end
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    dump_valid = (state == DUMP_SEND);
    dump_busy  = (state != DUMP_IDLE);
    dump_last  = dump_valid && (idx == LAST_IDX);
    if (dump_valid) dump_data = byte_in;
    else            dump_data = 8'd0;
  end

endmodule

// File: rtl/jt900h_rfile.sv
// JT900H register file: NBANK banks of four 32-bit accumulators, NPTR shared
// pointer registers (last is XSP), NRD combinational read ports, one
// byte/word/long write port, the bank pointer rfp and a byte-stream dump.
// Define JT900H_RFILE_BYPASS_EN to forward same-cycle writes to the reads.
module jt900h_rfile
  import jt900h_pkg::*;
#(
  parameter int          NBANK  = 4,
  parameter int          NPTR   = 4,
  parameter int          NRD    = 2,
  parameter logic [31:0] SP_RST = 32'h100,
  localparam int BW = $clog2(NBANK),
  localparam int AW = BW + 5
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD*2-1:0]  rd_size,
  output logic [NRD*32-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [1:0]        wr_size,
  input  logic [31:0]       wr_data,
  input  logic [1:0]        rfp_op,
  input  logic [BW-1:0]     rfp_din,
  output logic [BW-1:0]     rfp,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [7:0]        dump_data,
  output logic              dump_last
);

  localparam int NACC      = REG_BYTES * NBANK;
  localparam int ACC_BYTES = REG_BYTES * NACC;
  localparam int PTR_BYTES = REG_BYTES * NPTR;
  localparam int NBYTES    = ACC_BYTES + PTR_BYTES + 1;
  localparam int IW        = $clog2(NBYTES);
  localparam int PW        = (NPTR > 1) ? $clog2(NPTR) : 1;

  logic [31:0] acc [NACC];
  logic [31:0] ptr [NPTR];

  // Pointer field is two bits wide; fold it onto however many pointers exist
  function automatic logic [PW-1:0] ptr_index(input logic [1:0] sel);
    return PW'(int'(sel) % NPTR);
  endfunction

  logic            wr_fire;
  logic            wr_is_ptr;
  logic [BW+1:0]   wr_acc_idx;
  logic [PW-1:0]   wr_ptr_idx;

  assign wr_fire    = cen & wr_en;
  assign wr_is_ptr  = wr_addr[AW-1];
  assign wr_acc_idx = wr_addr[BW+3:ADDR_REG_LSB];
  assign wr_ptr_idx = ptr_index(wr_addr[3:ADDR_REG_LSB]);

  // Register storage: reset image, then lane-masked writes on cen&wr_en
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NACC; i++) acc[i] <= 32'd0;
      for (int p = 0; p < NPTR; p++) ptr[p] <= (p == NPTR - 1) ? SP_RST : 32'd0;
    end else if (wr_fire) begin
      if (wr_is_ptr)
        ptr[wr_ptr_idx] <= merge_bytes(ptr[wr_ptr_idx], wr_data, wr_size, wr_addr[1:0]);
      else
        acc[wr_acc_idx] <= merge_bytes(acc[wr_acc_idx], wr_data, wr_size, wr_addr[1:0]);
    end
  end

  // Bank pointer: load / wrapping inc / wrapping dec, independent of writes
  always_ff @(posedge clk) begin
    if (rst) begin
      rfp <= {BW{1'b0}};
    end else if (cen) begin
      case (rfp_op)
        RFP_LOAD: rfp <= rfp_din;
        RFP_INC:  rfp <= rfp + BW'(1);
        RFP_DEC:  rfp <= rfp - BW'(1);
        default:  rfp <= rfp;
      endcase
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0] ra;
    logic [1:0]    rs;
    logic [31:0]   stored;
    logic [31:0]   merged;
    logic          hit;

    assign ra = rd_addr[r*AW +: AW];
    assign rs = rd_size[r*2 +: 2];

    // Fetch the full addressed register
    always_comb begin
      stored = 32'd0;
      if (ra[AW-1]) stored = ptr[ptr_index(ra[3:ADDR_REG_LSB])];
      else          stored = acc[ra[BW+3:ADDR_REG_LSB]];
    end

`ifdef JT900H_RFILE_BYPASS_EN
    assign hit = wr_fire && (ra[AW-1] == wr_is_ptr) &&
                 (ra[AW-1] ? (ptr_index(ra[3:ADDR_REG_LSB]) == wr_ptr_idx)
                           : (ra[BW+3:ADDR_REG_LSB] == wr_acc_idx));
`else
    assign hit = 1'b0;
`endif

    assign merged = hit ? merge_bytes(stored, wr_data, wr_size, wr_addr[1:0]) : stored;
    assign rd_data[r*32 +: 32] = extract_bytes(merged, rs, ra[1:0]);
  end

  logic [IW-1:0] dump_idx;
  logic [IW-1:0] dump_pidx;
  logic [31:0]   dump_word;
  logic [31:0]   dump_lane;
  logic [7:0]    dump_byte;

  assign dump_pidx = dump_idx - IW'(ACC_BYTES);

  // Live byte for the dump index: accumulators, pointers, then the status byte
  always_comb begin
    dump_word = 32'd0;
    if (int'(dump_idx) < ACC_BYTES) begin
      dump_word = acc[dump_idx[BW+3:ADDR_REG_LSB]];
    end else if (int'(dump_idx) < ACC_BYTES + PTR_BYTES) begin
      dump_word = ptr[PW'(dump_pidx >> 2)];
    end else begin
      dump_word = {{(32-BW){1'b0}}, rfp};
    end
    dump_lane = extract_bytes(dump_word, SZ_BYTE, dump_idx[1:0]);
    dump_byte = dump_lane[7:0];
  end

  jt900h_rfile_dump #(.NBYTES(NBYTES)) u_dump (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .byte_in    (dump_byte),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_last  (dump_last),
    .dump_data  (dump_data),
    .idx        (dump_idx)
  );

endmodule

// File: tb/tb_jt900h_rfile.sv
// Self-checking bench for jt900h_rfile (NBANK=4, NPTR=4, NRD=2).
// The reference model views the register file as a flat byte array in dump
// order (acc bytes 0..63, pointer bytes 64..79) plus a bank pointer.
module tb_jt900h_rfile;

  localparam int NBANK = 4;
  localparam int NPTR  = 4;
  localparam int NB    = 16*NBANK + 4*NPTR + 1;
  localparam int NREG_BYTES = NB - 1;

  logic        clk = 1'b0;
  logic        rst, cen;
  logic [13:0] rd_addr;
  logic [3:0]  rd_size;
  logic [63:0] rd_data;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;
  logic [1:0]  rfp_op, rfp_din, rfp;
  logic        dump_start, dump_busy, dump_valid, dump_ready, dump_last;
  logic [7:0]  dump_data;

  always #5 clk = ~clk;

  jt900h_rfile #(.NBANK(NBANK), .NPTR(NPTR), .NRD(2), .SP_RST(32'h100)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .rd_addr(rd_addr), .rd_size(rd_size), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
    .rfp_op(rfp_op), .rfp_din(rfp_din), .rfp(rfp),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] mb [NREG_BYTES];
  logic [1:0] rfp_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic int reg_base(input logic [6:0] a);
    if (a[6]) return 16*NBANK + (int'(a[3:2]) % NPTR) * 4;
    return int'(a[5:2]) * 4;
  endfunction

  function automatic void m_write(input logic [6:0] a, input logic [1:0] sz, input logic [31:0] d);
    int b, h;
    b = reg_base(a);
    h = a[1] ? 2 : 0;
    if (sz == 2'd0) mb[b + int'(a[1:0])] = d[7:0];
    else if (sz == 2'd1) begin mb[b+h] = d[7:0]; mb[b+h+1] = d[15:8]; end
    else for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
  endfunction

  function automatic logic [31:0] m_read(input logic [6:0] a, input logic [1:0] sz);
    int b, h;
    b = reg_base(a);
    h = a[1] ? 2 : 0;
    if (sz == 2'd0) return {24'd0, mb[b + int'(a[1:0])]};
    if (sz == 2'd1) return {16'd0, mb[b+h+1], mb[b+h]};
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  function automatic logic [31:0] m_read_now(input logic [6:0] a, input logic [1:0] sz);
`ifdef JT900H_RFILE_BYPASS_EN
    logic [7:0]  save [NREG_BYTES];
    logic [31:0] v;
    if (cen && wr_en && !rst) begin
      save = mb;
      m_write(wr_addr, wr_size, wr_data);
      v = m_read(a, sz);
      mb = save;
      return v;
    end
`endif
    return m_read(a, sz);
  endfunction

  function automatic logic [7:0] m_dump(input int i);
    if (i < NREG_BYTES) return mb[i];
    return {6'd0, rfp_m};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NREG_BYTES; i++) mb[i] = 8'd0;
    mb[NREG_BYTES-4] = 8'h00;
    mb[NREG_BYTES-3] = 8'h01;
    rfp_m = 2'd0;
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic step();
    if (rst) m_reset();
    else if (cen) begin
      if (wr_en) m_write(wr_addr, wr_size, wr_data);
      case (rfp_op)
        2'd1:    rfp_m = rfp_din;
        2'd2:    rfp_m = 2'((int'(rfp_m) + 1) % NBANK);
        2'd3:    rfp_m = 2'((int'(rfp_m) + NBANK - 1) % NBANK);
        default: rfp_m = rfp_m;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input bit toggle, input int write_at, output int nbytes);
    bit done, wrote, have_hold;
    logic [7:0] hold_v;
    nbytes = 0; done = 0; wrote = 0; have_hold = 0; hold_v = 8'd0;
    cen = 1'b1; wr_en = 1'b0; rfp_op = 2'd0; dump_ready = 1'b0; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      dump_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      wr_en = 1'b0;
      if (nbytes == write_at && !wrote) begin
        wr_en = 1'b1; wr_addr = 7'h3C; wr_size = 2'd2; wr_data = $urandom; wrote = 1;
      end
      #1;
      check("dump_valid", {31'd0, dump_valid}, 32'd1);
      check("dump_busy", {31'd0, dump_busy}, 32'd1);
      if (have_hold) check("dump_hold", {24'd0, dump_data}, {24'd0, hold_v});
      check("dump_data", {24'd0, dump_data}, {24'd0, m_dump(nbytes)});
      check("dump_last", {31'd0, dump_last}, {31'd0, nbytes == NB - 1});
      if (dump_ready) begin
        nbytes++;
        have_hold = 0;
        if (nbytes == NB) done = 1;
      end else begin
        have_hold = 1;
        hold_v = dump_data;
      end
      step();
    end
    wr_en = 1'b0;
    dump_ready = 1'b0;
    if (!done) check("dump_timeout", 32'd0, 32'd1);
    #1;
    check("done_busy", {31'd0, dump_busy}, 32'd1);
    check("done_valid", {31'd0, dump_valid}, 32'd0);
    step();
    check("idle_busy", {31'd0, dump_busy}, 32'd0);
  endtask

  typedef struct {
    logic        cen;
    logic        wr_en;
    logic [6:0]  wa;
    logic [1:0]  ws;
    logic [31:0] wd;
    logic [6:0]  ra;
    logic [1:0]  rs;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [13];

  initial begin
    int n;
    vt[0]  = '{1'b1, 1'b1, 7'h00, 2'd2, 32'h11223344, 7'h01, 2'd0, 32'h00000033};
    vt[1]  = '{1'b1, 1'b0, 7'h00, 2'd0, 32'h00000000, 7'h02, 2'd1, 32'h00001122};
    vt[2]  = '{1'b1, 1'b1, 7'h03, 2'd0, 32'h000000AA, 7'h00, 2'd2, 32'hAA223344};
    vt[3]  = '{1'b0, 1'b1, 7'h00, 2'd2, 32'hFFFFFFFF, 7'h00, 2'd2, 32'hAA223344};
    vt[4]  = '{1'b1, 1'b1, 7'h04, 2'd1, 32'h00005566, 7'h04, 2'd2, 32'h00005566};
    vt[5]  = '{1'b1, 1'b1, 7'h06, 2'd1, 32'h00007788, 7'h04, 2'd2, 32'h77885566};
    vt[6]  = '{1'b1, 1'b0, 7'h00, 2'd0, 32'h00000000, 7'h07, 2'd0, 32'h00000077};
    vt[7]  = '{1'b1, 1'b1, 7'h08, 2'd3, 32'hCAFEF00D, 7'h08, 2'd2, 32'hCAFEF00D};
    vt[8]  = '{1'b1, 1'b1, 7'h41, 2'd0, 32'h0000005A, 7'h40, 2'd2, 32'h00005A00};
    vt[9]  = '{1'b1, 1'b0, 7'h00, 2'd0, 32'h00000000, 7'h01, 2'd1, 32'h00003344};
    vt[10] = '{1'b1, 1'b1, 7'h3C, 2'd2, 32'h12345678, 7'h3E, 2'd0, 32'h00000034};
    vt[11] = '{1'b1, 1'b0, 7'h00, 2'd0, 32'h00000000, 7'h7C, 2'd2, 32'h00000100};
    vt[12] = '{1'b1, 1'b1, 7'h4E, 2'd1, 32'h0000ABCD, 7'h4C, 2'd2, 32'hABCD0100};

    rst = 1'b1; cen = 1'b0; wr_en = 1'b0; wr_addr = 7'd0; wr_size = 2'd0; wr_data = 32'd0;
    rfp_op = 2'd0; rfp_din = 2'd0; dump_start = 1'b0; dump_ready = 1'b0;
    rd_addr = 14'd0; rd_size = 4'd0;
    m_reset();

    // Reset with cen low
    step(); step();
    rst = 1'b0;
    rd_addr[6:0] = 7'h4C; rd_size[1:0] = 2'd2;
    rd_addr[13:7] = 7'h00; rd_size[3:2] = 2'd2;
    #1;
    check("rst_xsp", rd_data[31:0], 32'h00000100);
    check("rst_acc0", rd_data[63:32], 32'h00000000);
    check("rst_rfp", {30'd0, rfp}, 32'd0);
    check("rst_dump", {21'd0, dump_busy, dump_valid, dump_last, dump_data}, 32'd0);

    // Table-driven write/read vectors
    for (int i = 0; i < 13; i++) begin
      cen = vt[i].cen; wr_en = vt[i].wr_en; wr_addr = vt[i].wa;
      wr_size = vt[i].ws; wr_data = vt[i].wd;
      step();
      cen = 1'b1; wr_en = 1'b0;
      rd_addr[6:0] = vt[i].ra; rd_size[1:0] = vt[i].rs;
      #1;
      check($sformatf("vec%0d", i), rd_data[31:0], vt[i].exp);
    end

    // Bank pointer sequence
    rfp_op = 2'd1; rfp_din = 2'd3; step(); check("rfp_load3", {30'd0, rfp}, 32'd3);
    rfp_op = 2'd2; step(); check("rfp_inc_wrap", {30'd0, rfp}, 32'd0);
    rfp_op = 2'd3; step(); check("rfp_dec_wrap", {30'd0, rfp}, 32'd3);
    rfp_op = 2'd1; rfp_din = 2'd2; step(); check("rfp_load2", {30'd0, rfp}, 32'd2);
    rfp_op = 2'd2; cen = 1'b0; step(); check("rfp_nocen", {30'd0, rfp}, 32'd2);
    cen = 1'b1; rfp_op = 2'd0; step(); check("rfp_hold", {30'd0, rfp}, 32'd2);
    rfp_op = 2'd2; wr_en = 1'b1; wr_addr = 7'h04; wr_size = 2'd2; wr_data = 32'h55AA55AA;
    step();
    rfp_op = 2'd0; wr_en = 1'b0; rd_addr[6:0] = 7'h04; rd_size[1:0] = 2'd2;
    #1;
    check("same_cyc_rfp", {30'd0, rfp}, 32'd3);
    check("same_cyc_wr", rd_data[31:0], 32'h55AA55AA);

    // Same-cycle write and read of acc5
    wr_en = 1'b1; wr_addr = 7'h14; wr_size = 2'd2; wr_data = 32'h01020304;
    step();
    wr_data = 32'hDEADBEEF;
    rd_addr[13:7] = 7'h14; rd_size[3:2] = 2'd2;
    rd_addr[6:0] = 7'h10; rd_size[1:0] = 2'd2;
    #1;
`ifdef JT900H_RFILE_BYPASS_EN
    check("bypass_same", rd_data[63:32], 32'hDEADBEEF);
`else
    check("bypass_same", rd_data[63:32], 32'h01020304);
`endif
    check("bypass_other", rd_data[31:0], m_read(7'h10, 2'd2));
    step();
    wr_en = 1'b0;
    #1;
    check("bypass_next", rd_data[63:32], 32'hDEADBEEF);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cen = ($urandom_range(0, 3) != 0);
      wr_en = $urandom; wr_addr = $urandom; wr_size = $urandom; wr_data = $urandom;
      rfp_op = $urandom; rfp_din = $urandom;
      rd_addr = $urandom; rd_size = $urandom;
      #1;
      check("rnd_rd0", rd_data[31:0], m_read_now(rd_addr[6:0], rd_size[1:0]));
      check("rnd_rd1", rd_data[63:32], m_read_now(rd_addr[13:7], rd_size[3:2]));
      check("rnd_rfp", {30'd0, rfp}, {30'd0, rfp_m});
      step();
    end

    // Dump of random contents, live write to acc15 while byte 5 is pending
    run_dump(1'b1, 5, n);
    check("dump_live_count", n, NB);

    // Dump straight after reset with ready toggling
    rst = 1'b1; step(); rst = 1'b0;
    run_dump(1'b1, -1, n);
    check("dump_rst_count", n, NB);

    // Reset in the middle of a dump, then restart
    cen = 1'b1; dump_start = 1'b1; step(); dump_start = 1'b0;
    dump_ready = 1'b1; n = 0;
    for (int cyc = 0; cyc < 50 && n < 10; cyc++) begin
      #1;
      if (dump_valid) n++;
      step();
    end
    check("abort_at", n, 10);
    rst = 1'b1; step(); rst = 1'b0; dump_ready = 1'b0;
    #1;
    check("abort_out", {21'd0, dump_busy, dump_valid, dump_last, dump_data}, 32'd0);
    step();
    check("abort_stay", {31'd0, dump_valid}, 32'd0);
    run_dump(1'b0, -1, n);
    check("restart_count", n, NB);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/jt900h_rfile.md
JT900H_RFILE -- requirements
Module: jt900h_rfile

Interface
REQ-001 SHALL have parameter NBANK, default 4, accumulator bank count; power of 2, range 2..8; BW=log2(NBANK).
REQ-002 SHALL have parameter NPTR, default 4, count of shared 32-bit pointer registers; the last one is XSP.
REQ-003 SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 SHALL have parameter SP_RST, default 32'h100, XSP reset value.
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous active-high; cen in 1, clock enable.
REQ-006 SHALL have ports rd_addr in NRD*(BW+5) (address format defined in REQ-010); rd_size in NRD*2 (0 byte, 1 word, 2 long); rd_data out NRD*32.
REQ-007 SHALL have write ports: wr_en in 1; wr_addr in BW+5; wr_size in 2; wr_data in 32.
REQ-008 SHALL have bank-pointer ports: rfp_op in 2 (0 hold, 1 load, 2 inc, 3 dec); rfp_din in BW; rfp out BW.
REQ-009 SHALL have dump ports: dump_start in 1; dump_busy out 1; dump_valid out 1; dump_ready in 1; dump_data out 8; dump_last out 1.

Function
REQ-010 Address bit BW+4 set SHALL select pointer [3:2] (modulo NPTR); clear SHALL select accumulator {bank[BW+3:4], reg[3:2]}; bits [1:0] SHALL select byte, with bit 1 selecting the word.
REQ-011 Reads SHALL be combinational: byte returns the addressed byte, word returns the addressed half, long returns all 32 bits; upper bits SHALL be zero.
REQ-012 Writes SHALL occur only on cen&wr_en and SHALL update only the addressed byte, half or long; byte lanes outside the size SHALL be unchanged; wr_size=3 SHALL be treated as long.
REQ-013 rfp SHALL update on cen: load takes rfp_din; inc wraps NBANK-1->0; dec wraps 0->NBANK-1.
REQ-014 wr_addr SHALL be absolute; a write and an rfp change in the same cycle SHALL both take effect independently.
REQ-015 The dump FSM SHALL have states IDLE, SEND and DONE; dump_start with cen in IDLE SHALL go to SEND with index 0; dump_start SHALL be ignored in SEND and DONE.
REQ-016 The SEND byte order SHALL be: accumulators 0..4*NBANK-1, then pointers 0..NPTR-1, each register LSB first, then one status byte {zeros, rfp}; total N=16*NBANK+4*NPTR+1 bytes.
REQ-017 dump_valid SHALL be 1 in SEND; the index SHALL advance on cen&dump_valid&dump_ready; dump_data SHALL be held while ready is low.
REQ-018 dump_last SHALL be high with the status byte; its transfer SHALL move the FSM to DONE, and DONE SHALL return to IDLE after one cen cycle.
REQ-019 dump_busy SHALL be high in SEND and DONE.
REQ-020 Dump data SHALL be read live: a write to a byte not yet sent SHALL appear in the stream.

Reset
REQ-021 On rst at a clk edge, regardless of cen: all accumulators and pointers SHALL clear to 0 except XSP=SP_RST; rfp=0; FSM=IDLE; dump_valid=0, dump_last=0, dump_busy=0, dump_data=0.
REQ-022 rst during SEND SHALL abort the dump with no further valid bytes.

Configuration
REQ-023 With JT900H_RFILE_BYPASS_EN defined, a read addressing a register being written in the same cycle (cen&wr_en) SHALL return the merged new bytes; without it, reads SHALL return the pre-write value.

Structure
REQ-024 Size encodings, rfp_op codes, FSM state encodings and the address-field helper constants SHALL live in the shared package jt900h_pkg.
REQ-025 The dump sequencer SHALL be the sub-module jt900h_rfile_dump; storage and read muxing SHALL remain in the top module.

Verification
REQ-026 Write long 32'h11223344 to acc0, then read byte addr 1 -> 8'h33; read word addr 2 -> 16'h1122.
REQ-027 Write byte 8'hAA to acc0 byte 3 over 32'h11223344 -> long read 32'hAA223344.
REQ-028 rfp=3 (NBANK=4) with inc -> 0; then dec -> 3; load 2 -> 2.
REQ-029 Same-cycle write 32'hDEAD_BEEF and read of acc5 -> BEEF... value with BYPASS_EN, old value without; next cycle both builds return 32'hDEADBEEF.
REQ-030 Dump after reset (NBANK=4, NPTR=4) with ready toggled every other cycle -> 81 bytes, all zero except bytes 76..77 = 8'h00, 8'h01 (XSP 0x100 LSB first); last byte 8'h00 with dump_last.
REQ-031 rst asserted mid-dump at byte 10 -> dump_valid=0 next cycle; a new dump_start restarts from byte 0.
